// File: rtl/casu_er_monitor.sv
// casu_er_monitor
//   Watches CPU/DMA activity against the live executable-region pointers
//   and raises a multi-cycle reset request to the core on any protocol
//   violation: bad entry, bad exit, writes or DMA into the region, an
//   interrupt inside it, or the pointers changing while executing in it.
//
// Ports
//   mclk, puc_rst         clock, synchronous active-high reset
//   pc, irq               program counter, interrupt-serviced strobe
//   data_addr, data_wr    CPU data write address/strobe
//   dma_addr, dma_en      DMA address/strobe
//   ER_min, ER_max        region bounds (sole entry / sole exit address)
//   casu_reset            registered reset request, RST_CYCLES long
//   in_er                 high while executing inside the region
//   last_cause            sticky code of the most recent violation
//   viol_cnt              saturating violation count
module casu_er_monitor #(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned VCNT_WD    = 8
) (
  input  logic               mclk,
  input  logic               puc_rst,
  input  logic [15:0]        pc,
  input  logic               irq,
  input  logic [15:0]        data_addr,
  input  logic               data_wr,
  input  logic [15:0]        dma_addr,
  input  logic               dma_en,
  input  logic [15:0]        ER_min,
  input  logic [15:0]        ER_max,
  output logic               casu_reset,
  output logic               in_er,
  output logic [2:0]         last_cause,
  output logic [VCNT_WD-1:0] viol_cnt
);

  typedef enum logic [1:0] {
    NOTEXEC = 2'd0,
    EXEC    = 2'd1,
    KILL    = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           kcnt_q, kcnt_d;
  logic [15:0]          pc_prev_q, pc_prev_d;
  logic [15:0]          snap_min_q, snap_min_d;
  logic [15:0]          snap_max_q, snap_max_d;
  logic                 casu_reset_q, casu_reset_d;
  logic                 in_er_q, in_er_d;
  logic [2:0]           last_cause_q, last_cause_d;
  logic [VCNT_WD-1:0]   viol_cnt_q, viol_cnt_d;

  logic                 er_valid, pc_in, data_in, dma_in;
  logic [2:0]           cause;
  logic                 viol;

  // An inverted pair (min > max) describes an empty region.
  always_comb begin
    er_valid = (ER_min <= ER_max);
    pc_in    = er_valid && (pc >= ER_min) && (pc <= ER_max);
    data_in  = er_valid && (data_addr >= ER_min) && (data_addr <= ER_max);
    dma_in   = er_valid && (dma_addr >= ER_min) && (dma_addr <= ER_max);
  end

  // Priority chain: lowest code wins. Detection is blanked while killing.
  always_comb begin
    cause = 3'd0;
    if (state_q != KILL) begin
      if (state_q == NOTEXEC && pc_in && pc != ER_min)                  cause = 3'd1;
      else if (state_q == EXEC && !pc_in && pc_prev_q != ER_max)        cause = 3'd2;
      else if (data_wr && data_in)                                      cause = 3'd3;
      else if (dma_en && dma_in)                                        cause = 3'd4;
      else if (state_q == EXEC && irq)                                  cause = 3'd5;
      else if (state_q == EXEC &&
               (ER_min != snap_min_q || ER_max != snap_max_q))          cause = 3'd6;
    end
    viol = (cause != 3'd0);
  end

  always_comb begin
    state_d      = state_q;
    kcnt_d       = kcnt_q;
    pc_prev_d    = pc_prev_q;
    snap_min_d   = snap_min_q;
    snap_max_d   = snap_max_q;
    last_cause_d = last_cause_q;
    viol_cnt_d   = viol_cnt_q;

    if (state_q != KILL) pc_prev_d = pc;

    unique case (state_q)
      NOTEXEC: begin
        if (!viol && pc_in && pc == ER_min) begin
          state_d    = EXEC;
          snap_min_d = ER_min;
          snap_max_d = ER_max;
        end
      end
      EXEC: begin
        if (!viol && !pc_in && pc_prev_q == ER_max) state_d = NOTEXEC;
      end
      KILL: begin
        if (kcnt_q <= 8'd1) begin
          state_d = NOTEXEC;
          kcnt_d  = 8'd0;
        end else begin
          kcnt_d  = kcnt_q - 8'd1;
        end
      end
      default: state_d = NOTEXEC;
    endcase

    // Violation overrides the normal transitions above.
    if (viol) begin
      state_d      = KILL;
      kcnt_d       = 8'(RST_CYCLES);
      last_cause_d = cause;
      if (viol_cnt_q != {VCNT_WD{1'b1}}) viol_cnt_d = viol_cnt_q + 1'b1;
    end

    // Outputs are registered copies of the next state: glitch-free.
    casu_reset_d = (state_d == KILL);
    in_er_d      = (state_d == EXEC);
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q      <= NOTEXEC;
      kcnt_q       <= 8'd0;
      pc_prev_q    <= 16'h0000;
      snap_min_q   <= 16'hE000;
      snap_max_q   <= 16'hEFFF;
      casu_reset_q <= 1'b0;
      in_er_q      <= 1'b0;
      last_cause_q <= 3'd0;
      viol_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      kcnt_q       <= kcnt_d;
      pc_prev_q    <= pc_prev_d;
      snap_min_q   <= snap_min_d;
      snap_max_q   <= snap_max_d;
      casu_reset_q <= casu_reset_d;
      in_er_q      <= in_er_d;
      last_cause_q <= last_cause_d;
      viol_cnt_q   <= viol_cnt_d;
    end
  end

  assign casu_reset = casu_reset_q;
  assign in_er      = in_er_q;
  assign last_cause = last_cause_q;
  assign viol_cnt   = viol_cnt_q;

endmodule

// File: doc/casu_er_monitor.md
# casu_er_monitor

Runtime monitor that sits directly downstream of the CASU executable-pointer peripheral. It consumes the live `ER_min`/`ER_max` pointers together with CPU and DMA bus activity, tracks whether execution is inside the executable region (ER), and detects protocol violations. On any violation it asserts a multi-cycle reset request to the core. A saturating violation counter and a sticky cause code are kept for debug.

## Interface
Parameters:
- `RST_CYCLES`, default 4: cycles `casu_reset` is held per violation; legal range 1..255.
- `VCNT_WD`, default 8: width of the violation counter.

Ports:
- `mclk`  in  1  main system clock; single clock domain.
- `puc_rst`  in  1  reset; synchronous, active-high.
- `pc`  in  16  current program counter.
- `irq`  in  1  interrupt being serviced this cycle.
- `data_addr`  in  16  CPU data bus address.
- `data_wr`  in  1  CPU data write strobe.
- `dma_addr`  in  16  DMA address.
- `dma_en`  in  1  DMA access strobe.
- `ER_min`  in  16  ER start / sole legal entry point, from the EP peripheral.
- `ER_max`  in  16  ER end / sole legal exit point, from the EP peripheral.
- `casu_reset`  out  1  reset request to the core.
- `in_er`  out  1  high while the FSM is in EXEC.
- `last_cause`  out  3  sticky code of the most recent violation.
- `viol_cnt`  out  `VCNT_WD`  saturating violation count.

## Operation
- In-ER test: `ER_min <= a <= ER_max`, unsigned 16-bit, inclusive at both ends. If `ER_min > ER_max`, no address is in the ER.
- Registers:
  - `pc_prev` holds the previous cycle's `pc`.
  - `snap_min` / `snap_max` hold the ER pointers latched on entry.
  - `kcnt` is the KILL down-counter.
- FSM states: NOTEXEC, EXEC, KILL.
  - NOTEXEC -> EXEC when `pc` is in the ER, `pc == ER_min`, and there is no violation. `snap_*` load `ER_*` on this transition.
  - EXEC -> NOTEXEC when `pc` is not in the ER, `pc_prev == ER_max`, and there is no violation.
  - Any state except KILL -> KILL on a violation.
  - KILL -> NOTEXEC when `kcnt` reaches 1.
- Violation causes, evaluated each cycle outside KILL. When several are true, the lowest code wins:
  - 1: NOTEXEC, `pc` in ER, `pc != ER_min` (bad entry).
  - 2: EXEC, `pc` not in ER, `pc_prev != ER_max` (bad exit).
  - 3: `data_wr` with `data_addr` in ER, in any state (ER immutability).
  - 4: `dma_en` with `dma_addr` in ER, in any state.
  - 5: EXEC and `irq`.
  - 6: EXEC and (`ER_min != snap_min` or `ER_max != snap_max`), i.e. pointers changed mid-execution.
- Cause 0 means no violation recorded since reset.
- In KILL:
  - All inputs are ignored and no new violations are detected.
  - `pc_prev` is not updated.
  - `snap_*` hold their values.
- `viol_cnt` increments by 1 per entry into KILL and saturates at all-ones; it never wraps.

## Timing
- Reset values: state NOTEXEC, `casu_reset` 0, `in_er` 0, `last_cause` 0, `viol_cnt` 0, `pc_prev` 16'h0000, `snap_min` 16'hE000, `snap_max` 16'hEFFF, `kcnt` 0.
- Reset has priority over every other event. Asserting `puc_rst` during KILL aborts the KILL: `casu_reset` is 0 on the cycle after the reset edge.
- Violation detection is combinational from the current inputs in cycle T. Starting at the T+1 edge:
  - state is KILL;
  - `casu_reset` is 1, registered (no glitches);
  - `last_cause` and `viol_cnt` are updated;
  - `in_er` is 0.
- `casu_reset` stays high for exactly `RST_CYCLES` cycles (T+1 .. T+`RST_CYCLES`). At T+`RST_CYCLES`+1 the state is NOTEXEC and detection resumes in that same cycle.
- `in_er` is registered and rises one cycle after the cycle in which `pc == ER_min` was presented.
- Back-to-back violations: a violation present in the first cycle after KILL starts a new KILL immediately, so `casu_reset` drops for exactly one cycle.
- Entry and exit at a single-word ER (`ER_min == ER_max`) are legal; no gap cycle is required.

## Test plan
- **Legal run.** Defaults (E000/EFFF). pc sequence 0x4000, 0xE000, 0xE002, 0xEFFF, 0x4010 -> `in_er` high for 3 cycles, no `casu_reset`, `viol_cnt` stays 0.
- **Bad entry.** pc 0x4000 then 0xE010 -> `casu_reset` high for 4 cycles starting next cycle, `last_cause` = 1, `viol_cnt` = 1, then NOTEXEC.
- **Bad exit plus simultaneous write.** In EXEC, pc jumps 0xE004 -> 0x4000 with `data_wr` to 0xE100 in the same cycle -> `last_cause` = 2 (priority), single KILL, `viol_cnt` = 1.
- **DMA and irq.**
  - `dma_en` with addr 0xEFFF while in NOTEXEC -> cause 4.
  - Separately, `irq` while in EXEC -> cause 5.
  - `dma_en` with addr 0xF000 -> no violation.
- **Pointer change mid-execution.** In EXEC, drive `ER_max` = 0xEF00 -> cause 6. After KILL, entry at 0xE000 is legal with the new `ER_max`.
- **Saturation and reset.**
  - Force 300 violations with `VCNT_WD` = 8 -> `viol_cnt` = 255.
  - Assert `puc_rst` on the 2nd cycle of a KILL -> `casu_reset` 0 the next cycle and all outputs at reset values.
